zbuffer_depth_test: RTL

- Per-pixel depth-test and z-buffer stage, directly downstream of the rasterizer.
- Consumes the rasterizer's pixel stream (x, y, depth, drawing strobe) plus a shaded colour, keeps an internal z-buffer of FB_WIDTH*FB_HEIGHT entries, and issues framebuffer writes only for fragments closer than the stored depth.
- Also owns the per-frame z-buffer clear sweep.

---
 rtl/zbuffer_depth_test.sv | 111 +++++++++++
 1 files changed

// File: rtl/zbuffer_depth_test.sv
// zbuffer_depth_test: 3-stage per-pixel depth test over an internal z-buffer with in-order forwarding and a drain-then-sweep frame clear
module zbuffer_depth_test #(
  parameter int COORD_WIDTH = 32,
  parameter int DEPTH_BIT_WIDTH = 16,
  parameter int COLOR_WIDTH = 16,
  parameter int FB_WIDTH = 320,
  parameter int FB_HEIGHT = 180,
  localparam int N = FB_WIDTH * FB_HEIGHT,
  localparam int AW = $clog2(N)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          clear_start,
  output logic                          clear_busy,
  output logic                          clear_done,
  input  logic                          px_valid,
  input  logic signed [COORD_WIDTH-1:0] px_x,
  input  logic signed [COORD_WIDTH-1:0] px_y,
  input  logic [DEPTH_BIT_WIDTH-1:0]    px_depth,
  input  logic [COLOR_WIDTH-1:0]        px_color,
  output logic                          px_ready,
  output logic                          fb_we,
  output logic [AW-1:0]                 fb_addr,
  output logic [COLOR_WIDTH-1:0]        fb_color,
  output logic [31:0]                   pass_count,
  output logic [31:0]                   reject_count
);
  typedef enum logic [1:0] {IDLE, DRAIN, CLEARING} state_t;
  state_t state, state_n;
  logic [AW-1:0] clr_addr, addr_c, s0_addr, s1_addr, s2_addr, z_wa;
  logic s0_v, s1_v, s2_v, s0_ok, s1_ok, s2_pass;
  logic [DEPTH_BIT_WIDTH-1:0] s0_depth, s1_depth, s2_depth, rd_q, stored, z_wd;
  logic [COLOR_WIDTH-1:0] s0_color, s1_color, s2_color;
  logic [DEPTH_BIT_WIDTH-1:0] zbuf [N];
  logic in_range, accept, drained, last, pass, z_we;
  assign in_range = !px_x[COORD_WIDTH-1] && (px_x[COORD_WIDTH-2:0] < (COORD_WIDTH-1)'(FB_WIDTH)) &&
                    !px_y[COORD_WIDTH-1] && (px_y[COORD_WIDTH-2:0] < (COORD_WIDTH-1)'(FB_HEIGHT));
  assign addr_c = px_y[AW-1:0] * AW'(FB_WIDTH) + px_x[AW-1:0];
  assign accept = px_valid && px_ready;
  assign drained = !(s0_v || s1_v || s2_v);
  assign last = clr_addr == AW'(N - 1);
  // the fragment one ahead writes on the same edge as this one's read, so its depth is forwarded
  assign stored = (s2_v && s2_pass && s2_addr == s1_addr) ? s2_depth : rd_q;
  assign pass = s1_v && s1_ok && (s1_depth < stored);
  assign z_we = (state == CLEARING) || pass;
  assign z_wa = (state == CLEARING) ? clr_addr : s1_addr;
  assign z_wd = (state == CLEARING) ? '1 : s1_depth;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = clear_start ? DRAIN : IDLE;
      DRAIN:    state_n = drained ? CLEARING : DRAIN;
      CLEARING: state_n = last ? IDLE : CLEARING;
      default:  state_n = IDLE;
    endcase
    px_ready = state == IDLE;
    clear_busy = state != IDLE;
  end
  always_ff @(posedge clk_in) begin
    if (z_we) zbuf[z_wa] <= z_wd;
    if (s0_v && s0_ok) rd_q <= zbuf[s0_addr];
  end
  always_ff @(posedge clk_in) begin
    s0_ok <= in_range;
    s0_addr <= addr_c;
    s0_depth <= px_depth;
    s0_color <= px_color;
    s1_ok <= s0_ok;
    s1_addr <= s0_addr;
    s1_depth <= s0_depth;
    s1_color <= s0_color;
    s2_pass <= pass;
    s2_addr <= s1_addr;
    s2_depth <= s1_depth;
    s2_color <= s1_color;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      clr_addr <= '0;
      clear_done <= 1'b0;
      s0_v <= 1'b0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      fb_we <= 1'b0;
      fb_addr <= '0;
      fb_color <= '0;
      pass_count <= '0;
      reject_count <= '0;
    end else begin
      state <= state_n;
      clr_addr <= (state == CLEARING) ? clr_addr + AW'(1) : '0;
      clear_done <= (state == CLEARING) && last;
      s0_v <= accept;
      s1_v <= s0_v;
      s2_v <= s1_v;
      fb_we <= s2_v && s2_pass;
      if (s2_v && s2_pass) begin
        fb_addr <= s2_addr;
        fb_color <= s2_color;
      end
      if (state == DRAIN && drained) begin
        pass_count <= '0;
        reject_count <= '0;
      end else if (s2_v) begin
        if (s2_pass) pass_count <= &pass_count ? pass_count : pass_count + 32'd1;
        else reject_count <= &reject_count ? reject_count : reject_count + 32'd1;
      end
    end
  end
endmodule
